// File: rtl/hardwired_control_unit_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU codes,
// state encoding and the decoded control word.
package cpu_ctrl_pkg;

  localparam int OPW  = 5;
  localparam int ALUW = 4;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10011;
  localparam logic [OPW-1:0] OP_IN   = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUW-1:0] ALU_AND = 4'd2;
  localparam logic [ALUW-1:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  typedef struct packed {
    logic [ALUW-1:0] alu_op;
    logic illegal, run, ba_out, r_out, r_in, grc, grb, gra;
    logic write, read, inc_pc, con_in, outport_in, y_in, ir_in, mdr_in;
    logic pc_in, z_in, mar_in, c_out, inport_out, mdr_out, zlow_out, zhi_out, pc_out;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [OPW-1:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

  function automatic logic is_alu_r_op(input logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_alu_i_op(input logic [OPW-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic [ALUW-1:0] alu_sel(input logic [OPW-1:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR,  OP_ORI:  return ALU_OR;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/hardwired_control_unit_if.sv
// Datapath-facing bundle: instruction/status inputs and every control strobe.
interface hardwired_control_unit_if;
  import cpu_ctrl_pkg::*;

  logic [31:0]     IR;
  logic            BranchMet, MemReady;
  logic            PCout, Zhiout, Zlowout, MDRout, InPortout, Cout;
  logic            MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn;
  logic            IncPC, Read, Write;
  logic            Gra, Grb, Grc, Rin, Rout, BAout;
  logic [ALUW-1:0] alu_op;
  logic            Run, Illegal;

  modport master (
    input  IR, BranchMet, MemReady,
    output PCout, Zhiout, Zlowout, MDRout, InPortout, Cout,
           MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn,
           IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
           alu_op, Run, Illegal
  );

  modport slave (
    output IR, BranchMet, MemReady,
    input  PCout, Zhiout, Zlowout, MDRout, InPortout, Cout,
           MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn,
           IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
           alu_op, Run, Illegal
  );
endinterface

// File: rtl/hardwired_control_unit_decode.sv
// Moore output decode: maps state + opcode (+ BranchMet in the branch
// commit step) to the full control word.
module control_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e         state,
  input  logic [OPW-1:0] opcode,
  input  logic           branch_met,
  output ctrl_t          ctrl
);

  logic mem_op, alu_r, alu_i;

  always_comb begin
    mem_op = is_mem_op(opcode);
    alu_r  = is_alu_r_op(opcode);
    alu_i  = is_alu_i_op(opcode);
    ctrl   = '0;
    ctrl.run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
      end
      S_T1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
      end
      S_T3: begin
        if (mem_op) begin
          ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
        end else if (alu_r || alu_i) begin
          ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
        end else if (opcode == OP_BR) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1;
        end else if (opcode == OP_JR) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
        end else if (opcode == OP_IN) begin
          ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end else if (opcode == OP_OUT) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      S_T4: begin
        if (mem_op || alu_i) begin
          ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = alu_sel(opcode);
        end else if (alu_r) begin
          ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_op = alu_sel(opcode);
        end else if (opcode == OP_BR) begin
          ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
        end
      end
      S_T5: begin
        if (opcode == OP_LDI || alu_r || alu_i) begin
          ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end else if (opcode == OP_LD || opcode == OP_ST) begin
          ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
        end else if (opcode == OP_BR) begin
          ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
        end
      end
      S_T6: begin
        if (opcode == OP_LD) begin
          ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
        end else if (opcode == OP_ST) begin
          ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
        end else if (opcode == OP_BR) begin
          ctrl.zlow_out = 1'b1; ctrl.pc_in = branch_met;
        end
      end
      S_T7: begin
        if (opcode == OP_LD) begin
          ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end else if (opcode == OP_ST) begin
          ctrl.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hardwired_control_unit.sv
// Hardwired Moore control FSM for the single-bus CPU datapath; only the
// state is registered, every strobe is decoded from state and IR.
module hardwired_control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic                     Clock,
  input  logic                     Clear,
  hardwired_control_unit_if.master bus
);

  state_e         state_q, state_d;
  logic [OPW-1:0] opcode;
  ctrl_t          ctrl;
  logic           unused_ir_bits;

  assign opcode         = bus.IR[31 -: OPW];
  assign unused_ir_bits = ^bus.IR[31-OPW:0];

  always_ff @(posedge Clock) begin
    if (Clear) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Memory steps (T1, ld-T6, st-T7) hold until MemReady; IR stays live from T3 on.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  if (bus.MemReady) state_d = S_T2;
      S_T2: begin
        if (opcode == OP_NOP)       state_d = S_T0;
        else if (opcode == OP_HALT) state_d = S_HALT;
        else                        state_d = S_T3;
      end
      S_T3: state_d = (is_mem_op(opcode) || is_alu_r_op(opcode) || is_alu_i_op(opcode)
                       || opcode == OP_BR) ? S_T4 : S_T0;
      S_T4: state_d = S_T5;
      S_T5: state_d = (opcode == OP_LD || opcode == OP_ST || opcode == OP_BR) ? S_T6 : S_T0;
      S_T6: begin
        if (opcode == OP_LD)      state_d = bus.MemReady ? S_T7 : S_T6;
        else if (opcode == OP_ST) state_d = S_T7;
        else                      state_d = S_T0;
      end
      S_T7: state_d = (opcode == OP_ST && !bus.MemReady) ? S_T7 : S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  control_decode u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .branch_met (bus.BranchMet),
    .ctrl       (ctrl)
  );

  assign bus.PCout     = ctrl.pc_out;
  assign bus.Zhiout    = ctrl.zhi_out;
  assign bus.Zlowout   = ctrl.zlow_out;
  assign bus.MDRout    = ctrl.mdr_out;
  assign bus.InPortout = ctrl.inport_out;
  assign bus.Cout      = ctrl.c_out;
  assign bus.MARin     = ctrl.mar_in;
  assign bus.Zin       = ctrl.z_in;
  assign bus.PCin      = ctrl.pc_in;
  assign bus.MDRin     = ctrl.mdr_in;
  assign bus.IRin      = ctrl.ir_in;
  assign bus.Yin       = ctrl.y_in;
  assign bus.OutPortin = ctrl.outport_in;
  assign bus.CONIn     = ctrl.con_in;
  assign bus.IncPC     = ctrl.inc_pc;
  assign bus.Read      = ctrl.read;
  assign bus.Write     = ctrl.write;
  assign bus.Gra       = ctrl.gra;
  assign bus.Grb       = ctrl.grb;
  assign bus.Grc       = ctrl.grc;
  assign bus.Rin       = ctrl.r_in;
  assign bus.Rout      = ctrl.r_out;
  assign bus.BAout     = ctrl.ba_out;
  assign bus.alu_op    = ctrl.alu_op;
  assign bus.Run       = ctrl.run;
  assign bus.Illegal   = ctrl.illegal;

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Bench for hardwired_control_unit: a per-instruction micro-step list model
// predicts the full control word every cycle under directed and random stimulus.
module tb_hardwired_control_unit;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  hardwired_control_unit_if bus();

  hardwired_control_unit dut (
    .Clock (clk),
    .Clear (clr),
    .bus   (bus)
  );

  localparam logic [28:0] M_PCOUT = 29'h1 << 0,  M_ZHI   = 29'h1 << 1,  M_ZLOW  = 29'h1 << 2;
  localparam logic [28:0] M_MDROUT= 29'h1 << 3,  M_INP   = 29'h1 << 4,  M_COUT  = 29'h1 << 5;
  localparam logic [28:0] M_MARIN = 29'h1 << 6,  M_ZIN   = 29'h1 << 7,  M_PCIN  = 29'h1 << 8;
  localparam logic [28:0] M_MDRIN = 29'h1 << 9,  M_IRIN  = 29'h1 << 10, M_YIN   = 29'h1 << 11;
  localparam logic [28:0] M_OUTP  = 29'h1 << 12, M_CONIN = 29'h1 << 13, M_INCPC = 29'h1 << 14;
  localparam logic [28:0] M_READ  = 29'h1 << 15, M_WRITE = 29'h1 << 16, M_GRA   = 29'h1 << 17;
  localparam logic [28:0] M_GRB   = 29'h1 << 18, M_GRC   = 29'h1 << 19, M_RIN   = 29'h1 << 20;
  localparam logic [28:0] M_ROUT  = 29'h1 << 21, M_BAOUT = 29'h1 << 22, M_RUN   = 29'h1 << 23;
  localparam logic [28:0] M_ILL   = 29'h1 << 24;

  logic [28:0] obs_w;
  assign obs_w = {bus.alu_op, bus.Illegal, bus.Run, bus.BAout, bus.Rout, bus.Rin, bus.Grc,
                  bus.Grb, bus.Gra, bus.Write, bus.Read, bus.IncPC, bus.CONIn, bus.OutPortin,
                  bus.Yin, bus.IRin, bus.MDRin, bus.PCin, bus.Zin, bus.MARin, bus.Cout,
                  bus.InPortout, bus.MDRout, bus.Zlowout, bus.Zhiout, bus.PCout};

  int nvec = 0;
  int nfail = 0;
  string tag = "init";

  // Model: mode 0 unknown, 1 reset, 2 running, 3 halted; k = step index (T-number).
  int mode = 0;
  int k = 0;
  logic [28:0] prog[$];
  bit stl[$];
  int br_idx;
  bit ends_halt;
  logic [31:0] cur_ir = 32'h0;
  logic cur_bm = 1'b0;
  int rd_cnt, pcin_cnt, ill_cnt, run_cnt;

  function automatic logic [28:0] alu(input int code);
    return logic'(0) | (29'(code) << 25);
  endfunction

  function automatic void build(input logic [4:0] op);
    prog = {M_PCOUT | M_MARIN | M_INCPC | M_ZIN, M_ZLOW | M_PCIN | M_READ | M_MDRIN,
            M_MDROUT | M_IRIN};
    stl = {1'b0, 1'b1, 1'b0};
    br_idx = -1;
    ends_halt = 1'b0;
    case (op)
      5'd1: begin prog.push_back(M_GRB|M_BAOUT|M_YIN); prog.push_back(M_COUT|M_ZIN);
                  prog.push_back(M_ZLOW|M_GRA|M_RIN); end
      5'd0: begin prog.push_back(M_GRB|M_BAOUT|M_YIN); prog.push_back(M_COUT|M_ZIN);
                  prog.push_back(M_ZLOW|M_MARIN); prog.push_back(M_READ|M_MDRIN);
                  prog.push_back(M_MDROUT|M_GRA|M_RIN); end
      5'd2: begin prog.push_back(M_GRB|M_BAOUT|M_YIN); prog.push_back(M_COUT|M_ZIN);
                  prog.push_back(M_ZLOW|M_MARIN); prog.push_back(M_GRA|M_ROUT|M_MDRIN);
                  prog.push_back(M_WRITE); end
      5'd3, 5'd4, 5'd5, 5'd6: begin
        prog.push_back(M_GRB|M_ROUT|M_YIN);
        prog.push_back(M_GRC|M_ROUT|M_ZIN|alu(int'(op) - 3));
        prog.push_back(M_ZLOW|M_GRA|M_RIN);
      end
      5'd12, 5'd13, 5'd14: begin
        prog.push_back(M_GRB|M_ROUT|M_YIN);
        prog.push_back(M_COUT|M_ZIN|alu(op == 5'd12 ? 0 : (op == 5'd13 ? 2 : 3)));
        prog.push_back(M_ZLOW|M_GRA|M_RIN);
      end
      5'd18: begin prog.push_back(M_GRA|M_ROUT|M_CONIN); prog.push_back(M_PCOUT|M_YIN);
                   prog.push_back(M_COUT|M_ZIN); prog.push_back(M_ZLOW); br_idx = 6; end
      5'd19: prog.push_back(M_GRA|M_ROUT|M_PCIN);
      5'd22: prog.push_back(M_INP|M_GRA|M_RIN);
      5'd23: prog.push_back(M_GRA|M_ROUT|M_OUTP);
      5'd26: ;
      5'd27: ends_halt = 1'b1;
      default: prog.push_back(M_ILL);
    endcase
    while (stl.size() < prog.size()) stl.push_back(1'b0);
    if (op == 5'd0) stl[6] = 1'b1;
    if (op == 5'd2) stl[7] = 1'b1;
  endfunction

  function automatic logic [28:0] expected_word();
    logic [28:0] w;
    if (mode != 2) return '0;
    build(cur_ir[31:27]);
    w = prog[k] | M_RUN;
    if (k == br_idx && cur_bm) w = w | M_PCIN;
    return w;
  endfunction

  task automatic model_update(input logic c, input logic m);
    build(cur_ir[31:27]);
    if (c) begin
      mode = 1;
    end else if (mode == 1) begin
      mode = 2; k = 0;
    end else if (mode == 2) begin
      if (!(stl[k] && !m)) begin
        k++;
        if (k == prog.size()) begin
          if (ends_halt) mode = 3;
          k = 0;
        end
      end
    end
  endtask

  task automatic check(input string t, input int observed, input int required);
    nvec++;
    assert (observed === required)
      else begin nfail++; $error("FAIL %s observed=%0d expected=%0d", t, observed, required); end
  endtask

  task automatic tick(input logic c, input logic m, input logic b);
    logic [28:0] exp_w;
    clr = c; bus.MemReady = m; bus.BranchMet = b; bus.IR = cur_ir; cur_bm = b;
    @(negedge clk);
    if (mode != 0) begin
      exp_w = expected_word();
      nvec++;
      assert (obs_w === exp_w)
        else begin nfail++; $error("FAIL %s obs=%h exp=%h", tag, obs_w, exp_w); end
    end
    if (obs_w[15] === 1'b1) rd_cnt++;
    if (obs_w[8]  === 1'b1) pcin_cnt++;
    if (obs_w[24] === 1'b1) ill_cnt++;
    if (obs_w[23] === 1'b1) run_cnt++;
    @(posedge clk);
    model_update(c, m);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic b, input int stall_k, input int nstall);
    int sc = 0;
    int cyc = 0;
    logic m;
    cur_ir = ir;
    rd_cnt = 0; pcin_cnt = 0; ill_cnt = 0; run_cnt = 0;
    do begin
      m = 1'b1;
      if (mode == 2 && k == stall_k && sc < nstall) begin m = 1'b0; sc++; end
      tick(1'b0, m, b);
      cyc++;
    end while (!(mode == 2 && k == 0) && mode != 3 && cyc < 64);
    if (cyc >= 64) check({tag, "_timeout"}, cyc, 0);
  endtask

  initial begin
    bus.IR = 32'h0; bus.MemReady = 1'b1; bus.BranchMet = 1'b0;
    #1;
    cur_ir = 32'h08800055;
    tag = "reset";
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    tag = "ldi"; run_instr(32'h08800055, 1'b0, -1, 0);
    tag = "ld_stall"; run_instr(32'h00800010, 1'b0, 6, 3);
    check("ld_read_cycles", rd_cnt, 5);
    tag = "br0"; run_instr(32'h9000000A, 1'b0, -1, 0);
    check("br0_pcin_cycles", pcin_cnt, 1);
    tag = "br1"; run_instr(32'h9000000A, 1'b1, -1, 0);
    check("br1_pcin_cycles", pcin_cnt, 2);
    tag = "st_stall"; run_instr(32'h10800020, 1'b0, 7, 2);
    tag = "t1_stall"; run_instr(32'h68800003, 1'b0, 1, 3);

    tag = "sub_clear";
    cur_ir = 32'h20918000;
    for (int i = 0; i < 16 && !(mode == 2 && k == 4); i++) tick(1'b0, 1'b1, 1'b0);
    check("sub_reach_t4", k, 4);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("sub_clear_t0_next", k, 1);
    for (int i = 0; i < 16 && !(mode == 2 && k == 0); i++) tick(1'b0, 1'b1, 1'b0);

    tag = "illegal"; run_instr(32'hF8000000, 1'b0, -1, 0);
    check("illegal_pulse_cycles", ill_cnt, 1);

    tag = "random";
    begin
      logic [4:0] ops [0:18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13,
                                 5'd14, 5'd18, 5'd19, 5'd22, 5'd23, 5'd26, 5'd7, 5'd31,
                                 5'd20, 5'd27};
      int halted = 0;
      logic c;
      for (int i = 0; i < 1500; i++) begin
        if (mode == 1 || (mode == 2 && k == 0)) begin
          if ($urandom_range(0, 29) == 0) cur_ir = {5'd27, 27'($urandom)};
          else cur_ir = {ops[$urandom_range(0, 17)], 27'($urandom)};
        end
        halted = (mode == 3) ? halted + 1 : 0;
        c = ($urandom_range(0, 49) == 0) || (halted > 4);
        tick(c, $urandom_range(0, 3) != 0, 1'($urandom));
      end
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
    end

    tag = "halt";
    run_instr(32'hD8000000, 1'b0, -1, 0);
    run_cnt = 0;
    for (int i = 0; i < 20; i++) tick(1'b0, $urandom_range(0, 1) != 0, 1'($urandom));
    check("halt_run_cycles", run_cnt, 0);
    tag = "halt_clear";
    tick(1'b1, 1'b1, 1'b0);
    run_cnt = 0;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("halt_exit_run", run_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/hardwired_control_unit.md
Name: hardwired_control_unit

Overview:
- Hardwired Moore control FSM for the single-bus CPU datapath (Datapath_P2).
- Generates every bus-select and register-load strobe for fetch and execute.
- Decodes the opcode held in IR and stalls on memory reads and writes via a ready handshake.
- Replaces hand-sequenced control and drives the datapath control inputs directly.

Parameters:
OPW, 5, opcode field width (IR[31:27])
ALUW, 4, alu_op width

Ports:
Clock  in  1  system clock, all state changes on rising edge
Clear  in  1  synchronous active-high reset
IR  in  32  instruction register contents from datapath
BranchMet  in  1  CON FF result from datapath
MemReady  in  1  memory completes current Read/Write this cycle
PCout, Zhiout, Zlowout, MDRout, InPortout, Cout  out  1 each  bus drivers
MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn  out  1 each  register loads
IncPC, Read, Write  out  1 each  PC increment, memory strobes
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/control
alu_op  out  ALUW  ALU function (ADD=0, SUB=1, AND=2, OR=3)
Run  out  1  high when not in RST/HALT
Illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- States: RST, T0..T7, HALT. Outputs are purely decoded from state+IR (Moore); only state is registered.
- Clear=1 at an edge -> RST, overriding all else (including mid-stall). In RST all outputs 0, alu_op=0, Run=0. Clear=0 at next edge: RST->T0.
- Fetch is the same for all opcodes:
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin; hold in T1 while MemReady=0, re-asserting the same outputs.
  - T2: MDRout IRin.
- Opcodes (IR[31:27]) and execute steps:
  - ld 00000 / ldi 00001 / st 00010:
    - T3: Grb BAout Yin.
    - T4: Cout alu_op=ADD Zin.
  - ldi T5: Zlowout Gra Rin -> T0.
  - ld:
    - T5: Zlowout MARin.
    - T6: Read MDRin, hold while MemReady=0.
    - T7: MDRout Gra Rin -> T0.
  - st:
    - T5: Zlowout MARin.
    - T6: Gra Rout MDRin.
    - T7: Write, hold while MemReady=0 -> T0.
  - add 00011 / sub 00100 / and 00101 / or 00110:
    - T3: Grb Rout Yin.
    - T4: Grc Rout alu_op Zin.
    - T5: Zlowout Gra Rin -> T0.
  - addi 01100 / andi 01101 / ori 01110:
    - T3: Grb Rout Yin.
    - T4: Cout alu_op Zin.
    - T5: Zlowout Gra Rin -> T0.
  - br 10010:
    - T3: Gra Rout CONIn.
    - T4: PCout Yin.
    - T5: Cout ADD Zin.
    - T6: Zlowout always; PCin=BranchMet sampled combinationally in T6 -> T0.
  - jr 10011, T3: Gra Rout PCin -> T0.
  - in 10110, T3: InPortout Gra Rin -> T0.
  - out 10111, T3: Gra Rout OutPortin -> T0.
  - nop 11010: T2 -> T0.
  - halt 11011: T2 -> HALT. HALT: all outputs 0, Run=0, exit only via Clear.
  - Any other opcode: T3 has all strobes 0, Illegal=1 -> T0.
- Stalls:
  - Read/Write are high only in T1, ld-T6 and st-T7.
  - Never both high at once.
  - MemReady is ignored in all other states.
- alu_op is 0 (ADD) whenever no ALU step is active.
- IR must be stable from T3 to end of instruction; the block does not latch it.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode localparams;
  - alu_op codes;
  - state encoding (4-bit, RST=0).
- One combinational sub-module control_decode (state, opcode, BranchMet -> control word).
- Top holds the state register and next-state logic.

Test Plan:
- Clear 2 cycles, IR=0x08800055 (ldi R1,0x55), MemReady=1 -> states RST,T0..T5,T0:
  - T3 Grb BAout Yin;
  - T4 Cout Zin alu_op=0;
  - T5 Zlowout Gra Rin;
  - no other strobes.
- ld (IR=0x00800010), MemReady=0 for 3 cycles in T6 -> Read=MDRin=1 for 4 consecutive cycles, then T7 MDRout Gra Rin, then T0.
- br (IR=0x9000000A) with BranchMet=0 then rerun with 1 -> T6 Zlowout=1 both runs; PCin=0 first run, 1 second.
- sub (IR=0x20918000) with Clear asserted during T4 -> next cycle state RST, Zin=0 and all outputs 0; after Clear drops, T0 next.
- halt (IR=0xD8000000) -> after T2 Run=0 and every output 0 for 20 cycles; Clear -> RST -> T0, Run=1.
- IR opcode 11111 -> Illegal=1 exactly one cycle at T3, all other strobes 0, T0 follows.
